// File: rtl/hpc3_pkg.sv
// Shared types and sizing helpers for the HPC3 gadget arbiter.
// Masking order d gives d+1 shares and d(d+1) random bits per gadget call.
package hpc3_pkg;

   localparam int DEF_ORDER  = 1;
   localparam int DEF_SHARES = DEF_ORDER + 1;

   typedef struct packed {
      logic valid;
      logic id;
   } tag_t;

   function automatic int half_rnd(input int d);
      return d * (d + 1) / 2;
   endfunction

   function automatic int shares(input int d);
      return d + 1;
   endfunction

endpackage

// File: rtl/hpc3_rr_arb2.sv
// Two-way round-robin arbiter gated by an enable.
// Priority pointer moves to the loser only when a grant is made.
module hpc3_rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic       r_prio;
   logic [1:0] w_gnt;

   // Grant: single requester wins outright, contention goes to r_prio
   always_comb begin
      w_gnt = 2'b00;
      if (i_en) begin
         if (&i_req) begin
            w_gnt = r_prio ? 2'b10 : 2'b01;
         end else begin
            w_gnt = i_req;
         end
      end
   end

   // Pointer: after granting 0, requester 1 is favoured, and vice versa
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (|w_gnt) begin
         r_prio <= w_gnt[0];
      end
   end

   assign o_gnt = w_gnt;

endmodule

// File: rtl/hpc3_gadget_arbiter.sv
// Shares one masked HPC3 AND gadget between two AND/NOR requesters.
// A tag pipe follows each issued op and routes g_c back to its owner.
module hpc3_gadget_arbiter
   import hpc3_pkg::*;
#(
   parameter int security_order = 1,
   parameter int GADGET_LATENCY = 1,
   parameter int CNT_W          = 16,
   localparam int NS = shares(security_order),
   localparam int RW = 2 * half_rnd(security_order)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic             req0_op,
   input  logic [NS-1:0]    req0_a,
   input  logic [NS-1:0]    req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic             req1_op,
   input  logic [NS-1:0]    req1_a,
   input  logic [NS-1:0]    req1_b,
   input  logic             rnd_valid,
   output logic             rnd_ready,
   input  logic [RW-1:0]    rnd_data,
   output logic [NS-1:0]    g_a,
   output logic [NS-1:0]    g_b,
   output logic [RW-1:0]    g_r,
   input  logic [NS-1:0]    g_c,
   output logic             rsp0_valid,
   output logic             rsp1_valid,
   output logic [NS-1:0]    rsp_c,
   output logic [CNT_W-1:0] issue_cnt
);

   logic [1:0]       w_gnt;
   logic             w_issue;
   logic             w_id;
   logic             w_op;
   logic [NS-1:0]    w_inv;
   logic [NS-1:0]    w_a;
   logic [NS-1:0]    w_b;

   logic [NS-1:0]    r_g_a;
   logic [NS-1:0]    r_g_b;
   logic [RW-1:0]    r_g_r;
   logic [CNT_W-1:0] r_cnt;
   tag_t             r_tag [GADGET_LATENCY];
   logic             r_rsp0;
   logic             r_rsp1;

   hpc3_rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (rnd_valid),
      .i_req ({req1_valid, req0_valid}),
      .o_gnt (w_gnt)
   );

   assign w_issue    = |w_gnt;
   assign w_id       = w_gnt[1];
   assign req0_ready = w_gnt[0];
   assign req1_ready = w_gnt[1];
   assign rnd_ready  = w_issue;

   // Winner select; NOR flips share 0 of both operands (De Morgan)
   always_comb begin
      w_op  = w_id ? req1_op : req0_op;
      w_inv = '0;
      w_inv[0] = w_op;
      w_a   = (w_id ? req1_a : req0_a) ^ w_inv;
      w_b   = (w_id ? req1_b : req0_b) ^ w_inv;
   end

   // Issue register: gadget inputs and counter move only on a grant
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_g_a <= '0;
         r_g_b <= '0;
         r_g_r <= '0;
         r_cnt <= '0;
      end else if (w_issue) begin
         r_g_a <= w_a;
         r_g_b <= w_b;
         r_g_r <= rnd_data;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Tag pipe mirrors gadget latency; bubbles carry valid=0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < GADGET_LATENCY; i++) begin
            r_tag[i] <= '0;
         end
      end else begin
         r_tag[0] <= '{valid: w_issue, id: w_id};
         for (int i = 1; i < GADGET_LATENCY; i++) begin
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   // Response strobes line up with g_c of the tagged op
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rsp0 <= 1'b0;
         r_rsp1 <= 1'b0;
      end else begin
         r_rsp0 <= r_tag[GADGET_LATENCY-1].valid
                   & ~r_tag[GADGET_LATENCY-1].id;
         r_rsp1 <= r_tag[GADGET_LATENCY-1].valid
                   & r_tag[GADGET_LATENCY-1].id;
      end
   end

   assign g_a        = r_g_a;
   assign g_b        = r_g_b;
   assign g_r        = r_g_r;
   assign issue_cnt  = r_cnt;
   assign rsp0_valid = r_rsp0;
   assign rsp1_valid = r_rsp1;
   assign rsp_c      = g_c;

endmodule
